// File: rtl/pc_gen_unit_way0_if.sv
// Fetch-request bus between the PC generator and instruction memory.
// The master side issues addresses; the slave side grants and responds.
interface pc_gen_unit_way0_if;
    logic        valid_o;
    logic [31:0] instAddr_o;
    logic        grant_i;
    logic        dataOk_i;
    logic [31:0] respAddr_o;
    logic        drop_o;

    modport master (
        output valid_o,
        output instAddr_o,
        output respAddr_o,
        output drop_o,
        input  grant_i,
        input  dataOk_i
    );

    modport slave (
        input  valid_o,
        input  instAddr_o,
        input  respAddr_o,
        input  drop_o,
        output grant_i,
        output dataOk_i
    );
endinterface

// File: rtl/pc_gen_unit_way0.sv
// PC generator for fetch way 0: issues sequential fetch addresses,
// tracks in-flight requests and marks wrong-path responses after a jump.
module pc_gen_unit_way0 #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        jumpFlag_i,
    input  logic [31:0] jumpAddr_i,
    output logic        err_o,
    pc_gen_unit_way0_if.master bus
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]    MAXO = 3'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   pc_q, pc_d;
    logic [2:0]    out_q, out_d;
    logic [2:0]    kill_q, kill_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic          err_q, err_d;
    logic [31:0]   fifo_q [MAX_OUTSTANDING];

    logic valid;
    logic issue;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Request/response qualification; a response with nothing in flight is ignored.
    always_comb begin
        valid = reset_n & ~stall_i & ~jumpFlag_i & (out_q < MAXO);
        issue = valid & bus.grant_i;
        pop   = bus.dataOk_i & (out_q != 3'd0);
    end

    // Next-state for PC, counters, FIFO pointers and the sticky error.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q;
        kill_d = kill_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        err_d  = err_q;

        if (jumpFlag_i) begin
            pc_d = {jumpAddr_i[31:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end

        if (issue && !pop) begin
            out_d = out_q + 3'd1;
        end else if (!issue && pop) begin
            out_d = out_q - 3'd1;
        end

        if (issue) begin
            wr_d = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end

        if (jumpFlag_i) begin
            kill_d = out_q - {2'b00, pop};
        end else if (pop && kill_q != 3'd0) begin
            kill_d = kill_q - 3'd1;
        end

        if (bus.dataOk_i && out_q == 3'd0) begin
            err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_PC;
            out_q  <= 3'd0;
            kill_q <= 3'd0;
            rd_q   <= '0;
            wr_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            kill_q <= kill_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            err_q  <= err_d;
        end
    end

    // Address FIFO storage, written with the PC on every issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= 32'h0;
            end
        end else if (issue) begin
            fifo_q[wr_q] <= pc_q;
        end
    end

    // Bus outputs; the head address is only meaningful while requests are in flight.
    always_comb begin
        bus.valid_o    = valid;
        bus.instAddr_o = pc_q;
        bus.respAddr_o = (out_q != 3'd0) ? fifo_q[rd_q] : 32'h0;
        bus.drop_o     = reset_n & bus.dataOk_i & (kill_q != 3'd0);
        err_o          = err_q;
    end

endmodule

// File: tb/tb_pc_gen_unit_way0.sv
// Testbench for pc_gen_unit_way0: scoreboard of issued addresses,
// each entry marked stale when a jump overtakes it.
module tb_pc_gen_unit_way0;

    localparam logic [31:0] RPC  = 32'h8000_0000;
    localparam int          MAXO = 2;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic        jumpFlag_i;
    logic [31:0] jumpAddr_i;
    logic        err_o;

    pc_gen_unit_way0_if bus ();

    pc_gen_unit_way0 #(
        .RESET_PC       (RPC),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall_i   (stall_i),
        .jumpFlag_i(jumpFlag_i),
        .jumpAddr_i(jumpAddr_i),
        .err_o     (err_o),
        .bus       (bus)
    );

    int          checks = 0;
    int          errors = 0;
    ent_t        sbq[$];
    logic [31:0] exp_pc;
    logic        exp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit st, input bit jp, input logic [31:0] ja,
                        input bit gr, input bit dk);
        ent_t        e;
        bit          ev;
        logic [31:0] head;
        @(negedge clk);
        stall_i      = st;
        jumpFlag_i   = jp;
        jumpAddr_i   = ja;
        bus.grant_i  = gr;
        bus.dataOk_i = dk;
        #1;
        chk("err", {31'b0, err_o}, {31'b0, exp_err});
        ev   = !st && !jp && (sbq.size() < MAXO);
        head = (sbq.size() > 0) ? sbq[0].addr : 32'h0;
        chk("valid", {31'b0, bus.valid_o}, {31'b0, ev});
        chk("instAddr", bus.instAddr_o, exp_pc);
        chk("respAddr", bus.respAddr_o, head);
        if (dk && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("drop", {31'b0, bus.drop_o}, {31'b0, e.stale});
        end else begin
            chk("drop", {31'b0, bus.drop_o}, 32'h0);
            if (dk) exp_err = 1'b1;
        end
        if (ev && gr) begin
            sbq.push_back('{addr: exp_pc, stale: 1'b0});
            exp_pc = exp_pc + 32'd4;
        end
        if (jp) begin
            foreach (sbq[i]) sbq[i].stale = 1'b1;
            exp_pc = {ja[31:2], 2'b00};
        end
    endtask

    task automatic drain();
        while (sbq.size() > 0) step(0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        reset_n      = 1'b0;
        stall_i      = 1'b0;
        jumpFlag_i   = 1'b0;
        jumpAddr_i   = 32'h0;
        bus.grant_i  = 1'b0;
        bus.dataOk_i = 1'b0;
        exp_pc       = RPC;
        exp_err      = 1'b0;

        // Reset state, including a response arriving while in reset.
        repeat (2) @(negedge clk);
        bus.grant_i  = 1'b1;
        bus.dataOk_i = 1'b1;
        #1;
        chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("rst_drop", {31'b0, bus.drop_o}, 32'h0);
        chk("rst_resp", bus.respAddr_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_pc", bus.instAddr_o, RPC);
        @(negedge clk);
        bus.dataOk_i = 1'b0;
        bus.grant_i  = 1'b0;
        reset_n      = 1'b1;

        // Streaming: grant every cycle, response one cycle after issue.
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        drain();

        // Back-pressure at the outstanding limit.
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 0);
        drain();

        // Jump with two in flight and no response.
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h8000_0103, 1, 0);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 1);

        // Jump in the same cycle as a response.
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'h9000_0010, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 1);

        // Response with nothing outstanding, then normal traffic.
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);

        // Wrap at the top of the address space, then stall.
        step(0, 1, 32'hFFFF_FFFE, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 1);
        step(1, 0, 32'h0, 1, 0);
        drain();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            bit dk;
            dk = (sbq.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 20 == 0);
            step($urandom % 5 == 0, $urandom % 12 == 0, $urandom,
                 $urandom % 4 != 0, dk);
        end
        drain();

        // Reset in the middle of operation discards in-flight state.
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        @(negedge clk);
        bus.grant_i  = 1'b1;
        bus.dataOk_i = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("mid_resp", bus.respAddr_o, 32'h0);
        chk("mid_drop", {31'b0, bus.drop_o}, 32'h0);
        chk("mid_err", {31'b0, err_o}, 32'h0);
        sbq.delete();
        exp_pc  = RPC;
        exp_err = 1'b0;
        @(negedge clk);
        bus.dataOk_i = 1'b0;
        bus.grant_i  = 1'b0;
        reset_n      = 1'b1;
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
